uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop input synchronizer.
// The line is sampled once per bit at the bit centre. The centre is found from
// the falling edge of the start bit. A low stop bit reports a frame error and
// then waits in BREAK until the line goes high again.
//
// Output handshake: o_rx_dv is a single-cycle valid strobe with no ready.
// The consumer must take o_rx_byte in that cycle. o_rx_byte then holds its
// value until the next good frame. o_frame_err is a single-cycle strobe and
// never coincides with o_rx_dv.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_serial,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned H     = (CLKS_PER_BIT - 1) / 2;
  // START sits in its first cycle with a count of 0, so the half-bit sample
  // happens when the count reaches H-1.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;

  // Next-state logic: synchronizer, bit timing, framing and strobes.
  always_comb begin
    rx_meta_d = i_rx_serial;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = 3'd0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State register; reset wins over any other event in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      byte_q    <= 8'h00;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  assign o_rx_dv     = dv_q;
  assign o_rx_byte   = byte_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule
